// File: rtl/twiddle_gen_pkg.sv
// rtl/twiddle_gen_pkg.sv - shared constants, state encoding and span check for twiddle_gen
`ifndef BITS
`define BITS 32
`endif

package twiddle_gen_pkg;

    localparam int FRAC = 21;
    localparam int ONE  = 1 << FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        MUL  = 2'd3
    } state_t;

    // Accepted spans are the powers of two from 2 to 128.
    function automatic logic h_legal(input logic [10:0] v);
        return (v >= 11'd2) && (v <= 11'd128) && ((v & (v - 11'd1)) == 11'd0);
    endfunction

endpackage

// File: rtl/twiddle_mul.sv
// rtl/twiddle_mul.sv - combinational Q-format complex multiply with round-half-up
module twiddle_mul #(
    parameter int W    = 32,
    parameter int FRAC = 21
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W-1:0] p_re,
    output logic signed [W-1:0] p_im
);

    localparam logic signed [2*W:0] HALF = (2*W+1)'(1) <<< (FRAC - 1);

    logic signed [2*W-1:0] rr, ii, ri, ir;
    logic signed [2*W:0]   sum_re, sum_im;

    // Sum carries one guard bit; the result wraps to W bits with no saturation.
    always_comb begin
        rr     = (2*W)'(a_re) * (2*W)'(b_re);
        ii     = (2*W)'(a_im) * (2*W)'(b_im);
        ri     = (2*W)'(a_re) * (2*W)'(b_im);
        ir     = (2*W)'(a_im) * (2*W)'(b_re);
        sum_re = (2*W+1)'(rr) - (2*W+1)'(ii) + HALF;
        sum_im = (2*W+1)'(ri) + (2*W+1)'(ir) + HALF;
        p_re   = W'(sum_re >>> FRAC);
        p_im   = W'(sum_im >>> FRAC);
    end

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - sequential twiddle generator streaming w^k for one FFT stage per start
module twiddle_gen #(
    parameter int W    = `BITS,
    parameter int FRAC = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [10:0]         h,
    input  logic                on,
    output logic [10:0]         lut_h,
    output logic                lut_on,
    input  logic signed [W-1:0] lut_sin,
    input  logic signed [W-1:0] lut_cos,
    output logic signed [W-1:0] w_re,
    output logic signed [W-1:0] w_im,
    output logic [9:0]          w_idx,
    output logic                w_last,
    output logic                w_valid,
    input  logic                w_ready,
    output logic                busy,
    output logic                done
);

    import twiddle_gen_pkg::*;

    localparam logic signed [W-1:0] ONE_W = W'(64'sd1 <<< FRAC);

    state_t              state, state_nx;
    logic [10:0]         h_q;
    logic                on_q;
    logic [9:0]          n_q, k_q;
    logic signed [W-1:0] c_q, s_q;
    logic signed [W-1:0] mul_re, mul_im;
    logic                accept, hs, last_k;

    assign accept  = (state == IDLE) && start && h_legal(h);
    assign last_k  = (k_q == n_q - 10'd1);
    assign hs      = (state == EMIT) && w_ready;

    assign w_valid = (state == EMIT);
    assign w_last  = w_valid && last_k;
    assign w_idx   = k_q;
    assign busy    = (state != IDLE);
    assign lut_h   = h_q;
    assign lut_on  = on_q;

    twiddle_mul #(.W(W), .FRAC(FRAC)) u_mul (
        .a_re (w_re),
        .a_im (w_im),
        .b_re (c_q),
        .b_im (s_q),
        .p_re (mul_re),
        .p_im (mul_im)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = EMIT;
            EMIT:    if (hs) state_nx = last_k ? IDLE : MUL;
            MUL:     state_nx = EMIT;
            default: state_nx = IDLE;
        endcase
    end

    // The ROMs see the latched span/direction continuously; capture happens at the end of LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q  <= '0;
            on_q <= 1'b0;
            n_q  <= '0;
            k_q  <= '0;
            c_q  <= '0;
            s_q  <= '0;
            w_re <= '0;
            w_im <= '0;
            done <= 1'b0;
        end else begin
            done <= hs && last_k;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        h_q  <= h;
                        on_q <= on;
                        n_q  <= h[10:1];
                        k_q  <= '0;
                    end
                end
                LOAD: begin
                    c_q  <= lut_cos;
                    s_q  <= lut_sin;
                    w_re <= ONE_W;
                    w_im <= '0;
                end
                MUL: begin
                    w_re <= mul_re;
                    w_im <= mul_im;
                    k_q  <= k_q + 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
